main_mem_ctrl: RTL
==================

# main_mem_ctrl

Main-memory line controller between the data cache controller and a single main-memory word bank. It accepts one cache-line read (refill) or write (writeback) request at a time and converts it into a burst of word accesses on the bank's port, after a programmable access latency. Read data are assembled into a full line and returned with a single-cycle completion pulse. Write requests get the same pulse as their acknowledge.

## Interface
- `WORDS_PER_LINE`, default 4: words per cache line. Must be a power of two, ≥2.
- `LATENCY`, default 4: idle wait cycles between accepting a request and the first bank access. 0 is legal.
- `clk` in 1: clock, rising edge.
- `rst` in 1: reset, asynchronous, active-low.
- `req_valid` in 1: cache controller presents a request.
- `req_ready` out 1: controller can accept a request.
- `req_we` in 1: 1 = line write, 0 = line read.
- `req_addr` in 28: word address. Low log2(`WORDS_PER_LINE`) bits are ignored.
- `req_wline` in 32*`WORDS_PER_LINE`: write line. Word k is in bits [32k+31:32k].
- `resp_valid` out 1: one-cycle completion pulse, for both reads and writes.
- `resp_rline` out 32*`WORDS_PER_LINE`: assembled read line. Same word packing as `req_wline`.
- `mem_addr` out 28: bank word address.
- `mem_we` out 1: bank write enable.
- `mem_wdata` out 32: bank write data.
- `mem_rdata` in 32: bank read data. Combinational from `mem_addr`, valid in the same cycle.

## Operation
- FSM states: IDLE, WAIT, XFER, RESP.
- **IDLE**
  - `req_ready`=1.
  - On `req_valid`&`req_ready`, latch the following:
    - base = `req_addr` with low index bits cleared
    - `req_we`
    - `req_wline`
  - If `LATENCY`>0: wcnt=`LATENCY`-1, go to WAIT.
  - If `LATENCY`==0: beat=0, go to XFER.
- **WAIT**
  - `req_ready`=0.
  - Decrement wcnt each cycle.
  - When wcnt==0: beat=0, go to XFER.
- **XFER**
  - One word per cycle:
    - `mem_addr`=base+beat
    - `mem_we`=latched we
    - `mem_wdata`=latched line word[beat]
  - On a read, `mem_rdata` is captured into `resp_rline` word[beat] at the cycle-ending edge.
  - beat increments each cycle. After beat==`WORDS_PER_LINE`-1, go to RESP.
  - Line words never cross a line boundary. base+beat touches only the index bits, so no carry into the upper address bits.
- **RESP**
  - `resp_valid`=1 for exactly one cycle, then go to IDLE.
  - `resp_valid` is not back-pressured; the consumer must take it.
- Outside XFER: `mem_we`=0, `mem_addr`=0, `mem_wdata`=0.
- `resp_rline` holds its value until the next read's XFER overwrites it. Writes never modify it.
- `req_valid` outside IDLE is ignored. There is no queuing; the requester holds the request until `req_ready`.
- Request inputs are sampled only on the accepting edge. Later changes have no effect.
- **Reset (`rst` low, any state, including mid-XFER)**
  - Return to IDLE immediately.
  - Output values during reset:
    - `req_ready`=1
    - `resp_valid`=0
    - `resp_rline`=0
    - `mem_we`=0
    - `mem_addr`=0
    - `mem_wdata`=0
  - The in-flight request is dropped with no response.
  - Words already written stay written.

## Timing
- Handshake at edge E0. Cycle n means the cycle after edge En.
  - Cycles 1..`LATENCY`: WAIT.
  - Cycles `LATENCY`+1 .. `LATENCY`+`WORDS_PER_LINE`: XFER, word k in cycle `LATENCY`+1+k.
  - Cycle `LATENCY`+`WORDS_PER_LINE`+1: `resp_valid`.
  - Next cycle: `req_ready`=1.
- Request-to-response latency is `LATENCY`+`WORDS_PER_LINE`+1 cycles. Defaults give 9.
- Throughput: one line per `LATENCY`+`WORDS_PER_LINE`+2 cycles. Defaults give 10.
- On a read, `resp_rline` is complete in the same cycle `resp_valid` is high.

## Test plan
- **Read refill:** bank words 0–3 = 0x10, 0x20, 0x30, 0x40; read `req_addr`=0x2.
  - `mem_addr` = 0, 1, 2, 3 in cycles 5–8.
  - `resp_valid` in cycle 9.
  - `resp_rline` = {0x40, 0x30, 0x20, 0x10}.
- **Writeback then read:** write `req_wline`={0xD,0xC,0xB,0xA} to `req_addr`=0x104.
  - `mem_we`=1 for exactly 4 cycles at 0x104–0x107.
  - `resp_valid` pulses; `resp_rline` is unchanged.
  - A following read of 0x104 returns {0xD,0xC,0xB,0xA}.
- **Back-to-back:** `req_valid` held high with two reads.
  - Second acceptance occurs 10 cycles after the first.
  - `req_ready`=0 in between.
  - Input changes while busy are ignored.
- **Reset mid-XFER:** assert `rst` during beat 1 of a write to 0x20.
  - All outputs take their reset values immediately.
  - No `resp_valid`.
  - Only word 0x20 was written; words 0x22–0x23 are unchanged.
  - A new request after release completes normally.
- **`LATENCY`=0:** read of 0x0.
  - XFER starts in cycle 1.
  - `resp_valid` in cycle 5.

Source files
------------

// File: rtl/main_mem_ctrl.sv
// Cache-line to word-bank controller: accepts one line read or write, waits a fixed
// access latency, bursts the words over the bank port, then pulses a completion.
module main_mem_ctrl #(
  parameter int WORDS_PER_LINE = 4,
  parameter int LATENCY        = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        req_valid,
  output logic                        req_ready,
  input  logic                        req_we,
  input  logic [27:0]                 req_addr,
  input  logic [32*WORDS_PER_LINE-1:0] req_wline,
  output logic                        resp_valid,
  output logic [32*WORDS_PER_LINE-1:0] resp_rline,
  output logic [27:0]                 mem_addr,
  output logic                        mem_we,
  output logic [31:0]                 mem_wdata,
  input  logic [31:0]                 mem_rdata
);

  localparam int LINE_W = 32 * WORDS_PER_LINE;
  localparam int IDX_W  = $clog2(WORDS_PER_LINE);
  localparam int WCNT_W = $clog2(LATENCY + 2);
  localparam logic [IDX_W-1:0]  LAST_BEAT = IDX_W'(WORDS_PER_LINE - 1);
  localparam logic [WCNT_W-1:0] WCNT_INIT = WCNT_W'((LATENCY > 0) ? LATENCY - 1 : 0);

  typedef enum logic [1:0] {IDLE, WAIT, XFER, RESP} state_t;

  state_t              state, state_nxt;
  logic [WCNT_W-1:0]   wcnt;
  logic [IDX_W-1:0]    beat;
  logic                accept;
  logic [27-IDX_W:0]   line_q;
  logic                we_q;
  logic [LINE_W-1:0]   wline_q;
  logic                unused_addr_lsb;

  // Word-within-line bits of the request address carry no information.
  assign unused_addr_lsb = ^req_addr[IDX_W-1:0];

  always_comb begin
    state_nxt  = state;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          accept    = 1'b1;
          state_nxt = (LATENCY > 0) ? WAIT : XFER;
        end
      end
      WAIT: if (wcnt == '0) state_nxt = XFER;
      XFER: if (beat == LAST_BEAT) state_nxt = RESP;
      RESP: begin
        resp_valid = 1'b1;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Bank port is driven only during the burst; all zeros otherwise.
  always_comb begin
    mem_addr  = '0;
    mem_we    = 1'b0;
    mem_wdata = '0;
    if (state == XFER) begin
      mem_addr  = {line_q, beat};
      mem_we    = we_q;
      mem_wdata = wline_q[{beat, 5'd0} +: 32];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      wcnt  <= '0;
      beat  <= '0;
    end else begin
      state <= state_nxt;
      if (accept)
        wcnt <= WCNT_INIT;
      else if (state == WAIT)
        wcnt <= wcnt - 1'b1;
      if (state_nxt == XFER && state != XFER)
        beat <= '0;
      else if (state == XFER)
        beat <= beat + 1'b1;
    end
  end

  // Request payload is captured once at acceptance and held for the whole burst.
  always_ff @(posedge clk) begin
    if (accept) begin
      line_q  <= req_addr[27:IDX_W];
      we_q    <= req_we;
      wline_q <= req_wline;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      resp_rline <= '0;
    else if (state == XFER && !we_q)
      resp_rline[{beat, 5'd0} +: 32] <= mem_rdata;
  end

endmodule
